elevator_controller_scan: RTL and testbench

Parametrised elevator car controller for N floors. It latches multiple floor requests into a pending bitmask and serves them in SCAN order: keep going in one direction while requests remain that way, then reverse. Each arrival runs a timed door-open dwell. It replaces the single-target up/down machine and drives the same `current_floor` output into the existing 7-segment decoder, plus new status outputs.

---
 rtl/elevator_pkg.sv | 14 +
 rtl/tick_timer.sv | 27 ++
 rtl/elevator_controller_scan.sv | 143 ++++++++++++++
 tb/tb_elevator_controller_scan.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared state encoding and direction constants for the elevator controller
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    DOOR_OPEN = 2'b01,
    MOVE_UP   = 2'b10,
    MOVE_DOWN = 2'b11
  } state_e;

  localparam logic UP   = 1'b0;
  localparam logic DOWN = 1'b1;

endpackage

// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - TICK_COUNT prescaler with synchronous clear and one-cycle tick
module tick_timer #(
  parameter int TICK_COUNT = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(TICK_COUNT);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(TICK_COUNT - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/elevator_controller_scan.sv
// rtl/elevator_controller_scan.sv - SCAN-order elevator car controller with request latch and timed door dwell
module elevator_controller_scan
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 10,
  parameter int FLOOR_W    = 4,
  parameter int TICK_COUNT = 10000000,
  parameter int DOOR_TICKS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  moving_up,
  output logic                  moving_down,
  output logic                  door_open,
  output logic                  idle
);

  localparam int DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;

  state_e                state_q, state_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d, set_mask, clr_mask;
  logic                  dir_q, dir_d;
  logic [DW-1:0]         door_q, door_d;
  logic                  open_q, open_d;
  logic                  tick, timer_clear, restart;
  logic                  req_ok, same_req, any_above, any_below;

  tick_timer #(.TICK_COUNT(TICK_COUNT)) u_tick_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .tick  (tick)
  );

  always_comb begin
    req_ok   = req_valid && ({1'b0, req_floor} < (FLOOR_W+1)'(NUM_FLOORS));
    same_req = req_ok && (req_floor == floor_q) && (state_q == IDLE || state_q == DOOR_OPEN);
    set_mask = '0;
    if (req_ok && !same_req) set_mask[req_floor] = 1'b1;
  end

  always_comb begin
    any_above = 1'b0;
    any_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_q[i] && ((FLOOR_W+1)'(i) > {1'b0, floor_q})) any_above = 1'b1;
      if (pending_q[i] && ((FLOOR_W+1)'(i) < {1'b0, floor_q})) any_below = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    dir_d    = dir_q;
    clr_mask = '0;
    restart  = 1'b0;
    open_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // A same-floor request in IDLE is remembered for one cycle and opens the door on the next edge.
        open_d = same_req;
        if (open_q) begin
          state_d = DOOR_OPEN;
        end else if (any_above && (dir_q == UP || !any_below)) begin
          state_d = MOVE_UP;
          dir_d   = UP;
        end else if (any_below) begin
          state_d = MOVE_DOWN;
          dir_d   = DOWN;
        end
      end
      MOVE_UP: begin
        if (tick) begin
          if (floor_q == FLOOR_W'(NUM_FLOORS - 1)) begin
            state_d = IDLE;
          end else begin
            floor_d = floor_q + 1'b1;
            if (pending_q[floor_d]) begin
              clr_mask[floor_d] = 1'b1;
              state_d           = DOOR_OPEN;
            end
          end
        end
      end
      MOVE_DOWN: begin
        if (tick) begin
          if (floor_q == '0) begin
            state_d = IDLE;
          end else begin
            floor_d = floor_q - 1'b1;
            if (pending_q[floor_d]) begin
              clr_mask[floor_d] = 1'b1;
              state_d           = DOOR_OPEN;
            end
          end
        end
      end
      DOOR_OPEN: begin
        if (same_req)                                     restart = 1'b1;
        else if (tick && door_q == DW'(DOOR_TICKS - 1))   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Arrival clear is applied last so it beats a same-edge set of the same floor.
    pending_d   = (pending_q | set_mask) & ~clr_mask;
    timer_clear = restart || (state_q == IDLE) || (state_d != state_q);
    if (timer_clear)                    door_d = '0;
    else if (state_q == DOOR_OPEN && tick) door_d = door_q + 1'b1;
    else                                door_d = door_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      floor_q   <= '0;
      pending_q <= '0;
      dir_q     <= UP;
      door_q    <= '0;
      open_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      pending_q <= pending_d;
      dir_q     <= dir_d;
      door_q    <= door_d;
      open_q    <= open_d;
    end
  end

  assign current_floor = floor_q;
  assign pending       = pending_q;
  assign moving_up     = (state_q == MOVE_UP);
  assign moving_down   = (state_q == MOVE_DOWN);
  assign door_open     = (state_q == DOOR_OPEN);
  assign idle          = (state_q == IDLE);

endmodule

// File: tb/tb_elevator_controller_scan.sv
// tb/tb_elevator_controller_scan.sv - self-checking bench: directed tables, corner sequences, random vs reference model
module tb_elevator_controller_scan;

  localparam int NF = 6;
  localparam int FW = 3;
  localparam int TC = 4;
  localparam int DT = 2;

  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_DOWN = 2;
  localparam int M_DOOR = 3;

  logic          clk = 1'b0;
  logic          clk_en = 1'b0;
  logic          reset;
  logic          req_valid;
  logic [FW-1:0] req_floor;
  logic [FW-1:0] current_floor;
  logic [NF-1:0] pending;
  logic          moving_up, moving_down, door_open, idle;

  elevator_controller_scan #(
    .NUM_FLOORS(NF), .FLOOR_W(FW), .TICK_COUNT(TC), .DOOR_TICKS(DT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_floor     (req_floor),
    .current_floor (current_floor),
    .pending       (pending),
    .moving_up     (moving_up),
    .moving_down   (moving_down),
    .door_open     (door_open),
    .idle          (idle)
  );

  always #5 clk = clk_en ? ~clk : 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode plus a countdown of cycles until the next event.
  int          m_mode, m_floor, m_rem;
  bit          m_dir_down, m_open;
  bit [NF-1:0] m_pend;

  typedef struct {
    int         e;
    logic [2:0] fl;
    logic [3:0] st;
    logic [5:0] pd;
  } vec_t;

  vec_t trip [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] dut_status();
    return {idle, door_open, moving_down, moving_up};
  endfunction

  function automatic logic [3:0] m_status();
    case (m_mode)
      M_IDLE:  return 4'b1000;
      M_DOOR:  return 4'b0100;
      M_UP:    return 4'b0001;
      default: return 4'b0010;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_floor = 0; m_rem = 0;
    m_dir_down = 1'b0; m_open = 1'b0; m_pend = '0;
  endtask

  task automatic model_step(input bit v, input int rf);
    bit inr, same, above, below, nopen;
    bit [NF-1:0] clr;
    int nf;
    clr = '0; above = 1'b0; below = 1'b0;
    inr  = v && (rf < NF);
    same = inr && (rf == m_floor) && (m_mode == M_IDLE || m_mode == M_DOOR);
    for (int i = 0; i < NF; i++) begin
      if (m_pend[i] && i > m_floor) above = 1'b1;
      if (m_pend[i] && i < m_floor) below = 1'b1;
    end
    nopen = (m_mode == M_IDLE) && same;
    case (m_mode)
      M_IDLE: begin
        if (m_open) begin
          m_mode = M_DOOR; m_rem = DT * TC;
        end else if (above && (!m_dir_down || !below)) begin
          m_mode = M_UP; m_dir_down = 1'b0; m_rem = TC;
        end else if (below) begin
          m_mode = M_DOWN; m_dir_down = 1'b1; m_rem = TC;
        end
      end
      M_UP, M_DOWN: begin
        m_rem--;
        if (m_rem == 0) begin
          nf = m_floor + ((m_mode == M_UP) ? 1 : -1);
          if (nf < 0 || nf >= NF) begin
            m_mode = M_IDLE;
          end else begin
            m_floor = nf;
            if (m_pend[nf]) begin
              clr[nf] = 1'b1; m_mode = M_DOOR; m_rem = DT * TC;
            end else begin
              m_rem = TC;
            end
          end
        end
      end
      default: begin
        if (same) m_rem = DT * TC;
        else begin
          m_rem--;
          if (m_rem == 0) m_mode = M_IDLE;
        end
      end
    endcase
    if (inr && !same) m_pend[rf] = 1'b1;
    m_pend = m_pend & ~clr;
    m_open = nopen;
  endtask

  task automatic apply(input bit v, input int rf);
    req_valid = v;
    req_floor = rf[FW-1:0];
    @(posedge clk);
    model_step(v, rf);
    #1;
    req_valid = 1'b0;
    check("model_state", {19'd0, current_floor, pending, dut_status()},
          {19'd0, m_floor[2:0], m_pend, m_status()});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int k, ns, stops [3];
    bit asked, prev_door, reached;

    reset = 1'b1; req_valid = 1'b0; req_floor = '0;
    model_reset();
    #1;
    check("reset_floor", current_floor, 0);
    check("reset_pending", pending, 0);
    check("reset_status", dut_status(), 4'b1000);
    #20 clk_en = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;

    trip[0] = '{0,  3'd0, 4'b1000, 6'b001000};
    trip[1] = '{1,  3'd0, 4'b0001, 6'b001000};
    trip[2] = '{4,  3'd0, 4'b0001, 6'b001000};
    trip[3] = '{5,  3'd1, 4'b0001, 6'b001000};
    trip[4] = '{8,  3'd1, 4'b0001, 6'b001000};
    trip[5] = '{9,  3'd2, 4'b0001, 6'b001000};
    trip[6] = '{12, 3'd2, 4'b0001, 6'b001000};
    trip[7] = '{13, 3'd3, 4'b0100, 6'b000000};
    trip[8] = '{20, 3'd3, 4'b0100, 6'b000000};
    trip[9] = '{21, 3'd3, 4'b1000, 6'b000000};
    k = 0;
    for (int e = 0; e <= 21; e++) begin
      if (e == 0) apply(1'b1, 3);
      else        apply(1'b0, 0);
      if (k < 10 && trip[k].e == e) begin
        check("trip_floor", current_floor, trip[k].fl);
        check("trip_status", dut_status(), trip[k].st);
        check("trip_pending", pending, trip[k].pd);
        k++;
      end
    end

    // SCAN ordering: requests behind and ahead of the car while it climbs.
    do_reset();
    apply(1'b1, 5);
    asked = 1'b0; ns = 0; prev_door = 1'b0;
    for (int c = 0; c < 400 && !(ns == 3 && idle); c++) begin
      if (!asked && moving_up && current_floor == 2) begin
        apply(1'b1, 4);
        apply(1'b1, 1);
        asked = 1'b1;
      end else begin
        apply(1'b0, 0);
      end
      if (door_open && !prev_door && ns < 3) begin
        stops[ns] = int'(current_floor);
        if (ns == 1) check("scan_pending_after_5", pending, 6'b000010);
        if (ns == 2) check("scan_pending_after_1", pending, 6'b000000);
        ns++;
      end
      prev_door = door_open;
    end
    check("scan_stop_count", ns, 3);
    if (ns == 3) begin
      check("scan_stop0", stops[0], 4);
      check("scan_stop1", stops[1], 5);
      check("scan_stop2", stops[2], 1);
    end

    // Same-floor request opens the door, a repeat restarts the dwell.
    do_reset();
    apply(1'b1, 0);
    check("same_wait_door", door_open, 1'b0);
    apply(1'b0, 0);
    check("same_door_open", door_open, 1'b1);
    check("same_pending", pending, 0);
    for (int j = 0; j < 3; j++) apply(1'b0, 0);
    apply(1'b1, 0);
    for (int j = 1; j <= 8; j++) begin
      apply(1'b0, 0);
      if (j == 4) check("restart_held_open", door_open, 1'b1);
      if (j == 7) check("restart_still_open", door_open, 1'b1);
      if (j == 8) check("restart_closed", idle, 1'b1);
    end

    // Out-of-range floors are ignored.
    apply(1'b1, 6);
    apply(1'b1, 7);
    check("oor_pending", pending, 0);
    check("oor_idle", idle, 1'b1);
    for (int j = 0; j < 3; j++) apply(1'b0, 0);
    check("oor_still_idle", dut_status(), 4'b1000);

    // Asynchronous reset in the middle of a move.
    do_reset();
    apply(1'b1, 5);
    asked = 1'b0; reached = 1'b0;
    for (int c = 0; c < 40 && !reached; c++) begin
      if (!asked && current_floor == 2) begin
        apply(1'b1, 4);
        asked = 1'b1;
      end else begin
        apply(1'b0, 0);
      end
      reached = moving_up && current_floor == 2 && pending == 6'b110000;
    end
    check("midmove_reached", reached, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("midmove_floor", current_floor, 0);
    check("midmove_pending", pending, 0);
    check("midmove_status", dut_status(), 4'b1000);
    #1 reset = 1'b0;
    model_reset();

    for (int c = 0; c < 1500; c++) begin
      int rf;
      bit v;
      v  = ($urandom_range(0, 3) == 0);
      rf = ($urandom_range(0, 5) == 0) ? m_floor : int'($urandom_range(0, 7));
      apply(v, rf);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
